comp_packer_frontend: RTL and testbench



---
 rtl/comp_packer_frontend_if.sv | 23 ++
 rtl/comp_packer_frontend.sv | 259 +++++++++++++++++++++++++
 tb/tb_comp_packer_frontend.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_packer_frontend_if.sv
// ---------------------------------------------------------------------------
// comp_packer_frontend_if
// AXI-Stream bundle used on both sides of comp_packer_frontend.
//   tdata  [DATA_W-1:0]    data
//   tkeep  [DATA_W/8-1:0]  byte enables
//   tvalid                 beat valid
//   tlast                  end of packet
//   tready                 sink ready
// master: drives tdata/tkeep/tvalid/tlast, samples tready.
// slave : samples tdata/tkeep/tvalid/tlast, drives tready.
// ---------------------------------------------------------------------------
interface comp_packer_frontend_if #(
   parameter int DATA_W = 256
);
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic                tvalid;
   logic                tlast;
   logic                tready;

   modport master (output tdata, tkeep, tvalid, tlast, input  tready);
   modport slave  (input  tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/comp_packer_frontend.sv
// ---------------------------------------------------------------------------
// comp_packer_frontend
// Sits between the RX AXI-Stream and the DMA stream. Non-compressible packets
// pass through unchanged. Compressible packets pass HDR_BEATS header beats
// unchanged, then every payload beat is coded lane by lane into a group
// (2-bit code bitmap + variable-size lane payloads) and the groups are
// bit-packed into full DATA_W beats, closed by one exact-length tlast beat.
//
// Ports
//   aclk, areset    clock, asynchronous active-high reset
//   s_axis          input stream (slave modport)
//   m_axis          output stream, fully registered (master modport)
//   comp_en         compress request, sampled on the first beat of a packet
//   pkt_is_comp     current / last packet is being compressed
//   comp_bytes_out  running count of compressed-section bytes emitted (wraps)
// ---------------------------------------------------------------------------
module comp_packer_frontend #(
   parameter int DATA_W    = 256,
   parameter int LANE_W    = 32,
   parameter int HDR_BEATS = 4
) (
   input  logic                   aclk,
   input  logic                   areset,
   comp_packer_frontend_if.slave  s_axis,
   comp_packer_frontend_if.master m_axis,
   input  logic                   comp_en,
   output logic                   pkt_is_comp,
   output logic [31:0]            comp_bytes_out
);
   localparam int LANES  = DATA_W / LANE_W;
   localparam int MAP_W  = 2 * LANES;
   localparam int GRP_W  = MAP_W + DATA_W;
   localparam int BUF_W  = 2 * DATA_W + MAP_W;
   localparam int CUR_W  = $clog2(BUF_W + 1);
   localparam int KEEP_W = DATA_W / 8;
   localparam int LKEEP  = LANE_W / 8;

   localparam logic [CUR_W-1:0]  DATA_W_C = CUR_W'(DATA_W);
   localparam logic [7:0]        HDR_C    = 8'(HDR_BEATS);
   localparam logic [LANE_W-1:0] LIM_01   = LANE_W'(1) << (LANE_W / 4);
   localparam logic [LANE_W-1:0] LIM_10   = LANE_W'(1) << (LANE_W / 2);

   typedef enum logic [2:0] {IDLE, BYPASS, HEADER, COMP_IN, PACK, EMIT} state_t;

   state_t              state_q, state_d;
   logic [7:0]          hdr_cnt_q, hdr_cnt_d;
   logic                run_q, run_d;
   logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
   logic [KEEP_W-1:0]   m_tkeep_q, m_tkeep_d;
   logic                m_tvalid_q, m_tvalid_d;
   logic                m_tlast_q, m_tlast_d;
   logic                pkt_is_comp_q, pkt_is_comp_d;
   logic [DATA_W-1:0]   in_data_q, in_data_d;
   logic [KEEP_W-1:0]   in_keep_q, in_keep_d;
   logic                last_flag_q, last_flag_d;
   logic [BUF_W-1:0]    buf_q, buf_d;
   logic [CUR_W-1:0]    cursor_q, cursor_d;
   logic [31:0]         comp_bytes_q, comp_bytes_d;

   logic                s_ready;
   logic                out_free;
   logic [GRP_W-1:0]    grp;
   logic [CUR_W-1:0]    glen;
   logic [CUR_W-1:0]    tail_bytes;
   logic [KEEP_W-1:0]   tail_keep;

   // ------------------------------------------------------------------------
   // Group builder: codes each lane of the registered payload beat and lays
   // the payloads back to back after the bitmap. A lane's value is already
   // below 2^size for its code, so it can be ORed in without masking.
   // ------------------------------------------------------------------------
   always_comb begin
      logic [LANE_W-1:0] lane;
      logic [1:0]        code;
      logic [CUR_W-1:0]  off;
      grp = '0;
      off = CUR_W'(MAP_W);
      for (int i = 0; i < LANES; i++) begin
         lane = in_data_q[i*LANE_W +: LANE_W];
         // A lane with any disabled byte carries no valid data.
         if (!(&in_keep_q[i*LKEEP +: LKEEP])) lane = '0;
         if (lane == '0)         code = 2'b00;
         else if (lane < LIM_01) code = 2'b01;
         else if (lane < LIM_10) code = 2'b10;
         else                    code = 2'b11;
         grp[2*i +: 2] = code;
         grp = grp | (GRP_W'(lane) << off);
         case (code)
            2'b01:   off = off + CUR_W'(LANE_W / 4);
            2'b10:   off = off + CUR_W'(LANE_W / 2);
            2'b11:   off = off + CUR_W'(LANE_W);
            default: off = off;
         endcase
      end
      glen = off;
   end

   // Tail beat length: the cursor is always a whole number of bytes, the
   // rounding only guards against a non-byte-aligned configuration.
   always_comb begin
      tail_bytes = (cursor_q + CUR_W'(7)) >> 3;
      for (int b = 0; b < KEEP_W; b++) begin
         tail_keep[b] = (CUR_W'(b) < tail_bytes);
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / datapath
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets its default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      hdr_cnt_d     = hdr_cnt_q;
      run_d         = 1'b1;
      m_tdata_d     = m_tdata_q;
      m_tkeep_d     = m_tkeep_q;
      m_tlast_d     = m_tlast_q;
      // A beat sitting in the output register leaves on tready; it is
      // reloaded below whenever a new beat is produced in the same cycle.
      m_tvalid_d    = m_tvalid_q && !m_axis.tready;
      pkt_is_comp_d = pkt_is_comp_q;
      in_data_d     = in_data_q;
      in_keep_d     = in_keep_q;
      last_flag_d   = last_flag_q;
      buf_d         = buf_q;
      cursor_d      = cursor_q;
      comp_bytes_d  = comp_bytes_q;
      s_ready       = 1'b0;
      out_free      = !m_tvalid_q || m_axis.tready;

      unique case (state_q)
         IDLE, BYPASS, HEADER: begin
            // One-deep pass-through; a completed header stops intake until
            // the last header beat has left the output register.
            s_ready = run_q && out_free &&
                      !(state_q == HEADER && hdr_cnt_q == HDR_C);
            if (s_ready && s_axis.tvalid) begin
               m_tdata_d  = s_axis.tdata;
               m_tkeep_d  = s_axis.tkeep;
               m_tlast_d  = s_axis.tlast;
               m_tvalid_d = 1'b1;
               if (state_q == IDLE) begin
                  pkt_is_comp_d = comp_en && !s_axis.tlast;
                  if (s_axis.tlast) begin
                     state_d = IDLE;
                  end else if (comp_en) begin
                     hdr_cnt_d = 8'd1;
                     state_d   = (HDR_BEATS == 1) ? COMP_IN : HEADER;
                  end else begin
                     state_d = BYPASS;
                  end
               end else if (state_q == BYPASS) begin
                  if (s_axis.tlast) state_d = IDLE;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 8'd1;
                  if (s_axis.tlast) state_d = IDLE;
               end
            end else if (state_q == HEADER && hdr_cnt_q == HDR_C && out_free) begin
               state_d = COMP_IN;
            end
         end

         COMP_IN: begin
            s_ready = 1'b1;
            if (s_axis.tvalid) begin
               in_data_d   = s_axis.tdata;
               in_keep_d   = s_axis.tkeep;
               last_flag_d = s_axis.tlast;
               state_d     = PACK;
            end
         end

         PACK: begin
            buf_d    = buf_q | (BUF_W'(grp) << cursor_q);
            cursor_d = cursor_q + glen;
            state_d  = EMIT;
         end

         EMIT: begin
            if (last_flag_q && cursor_q <= DATA_W_C) begin
               if (out_free) begin
                  m_tdata_d    = buf_q[DATA_W-1:0];
                  m_tkeep_d    = tail_keep;
                  m_tlast_d    = 1'b1;
                  m_tvalid_d   = 1'b1;
                  comp_bytes_d = comp_bytes_q + 32'(tail_bytes);
                  buf_d        = '0;
                  cursor_d     = '0;
                  state_d      = IDLE;
               end
            end else if (cursor_q >= DATA_W_C) begin
               if (out_free) begin
                  m_tdata_d    = buf_q[DATA_W-1:0];
                  m_tkeep_d    = '1;
                  m_tlast_d    = 1'b0;
                  m_tvalid_d   = 1'b1;
                  comp_bytes_d = comp_bytes_q + 32'(KEEP_W);
                  buf_d        = buf_q >> DATA_W;
                  cursor_d     = cursor_q - DATA_W_C;
                  // Skip the idle EMIT cycle when nothing more is owed.
                  if (!last_flag_q && cursor_d < DATA_W_C) state_d = COMP_IN;
               end
            end else begin
               state_d = COMP_IN;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the values computed in the previous cycle regardless of order.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q       <= IDLE;
         hdr_cnt_q     <= '0;
         run_q         <= 1'b0;
         m_tdata_q     <= '0;
         m_tkeep_q     <= '0;
         m_tvalid_q    <= 1'b0;
         m_tlast_q     <= 1'b0;
         pkt_is_comp_q <= 1'b0;
         in_data_q     <= '0;
         in_keep_q     <= '0;
         last_flag_q   <= 1'b0;
         // NOTE: the pack buffer must be reset even though it is wide: PACK
         // ORs new groups into it, so stale bits would corrupt the next packet.
         buf_q         <= '0;
         cursor_q      <= '0;
         comp_bytes_q  <= '0;
      end else begin
         state_q       <= state_d;
         hdr_cnt_q     <= hdr_cnt_d;
         run_q         <= run_d;
         m_tdata_q     <= m_tdata_d;
         m_tkeep_q     <= m_tkeep_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tlast_q     <= m_tlast_d;
         pkt_is_comp_q <= pkt_is_comp_d;
         in_data_q     <= in_data_d;
         in_keep_q     <= in_keep_d;
         last_flag_q   <= last_flag_d;
         buf_q         <= buf_d;
         cursor_q      <= cursor_d;
         comp_bytes_q  <= comp_bytes_d;
      end
   end

   assign s_axis.tready  = s_ready;
   assign m_axis.tdata   = m_tdata_q;
   assign m_axis.tkeep   = m_tkeep_q;
   assign m_axis.tvalid  = m_tvalid_q;
   assign m_axis.tlast   = m_tlast_q;
   assign pkt_is_comp    = pkt_is_comp_q;
   assign comp_bytes_out = comp_bytes_q;

endmodule

// File: tb/tb_comp_packer_frontend.sv
// ---------------------------------------------------------------------------
// tb_comp_packer_frontend
// Directed bench for comp_packer_frontend (DATA_W=256, LANE_W=32,
// HDR_BEATS=2). Expected beats are hand-computed and queued per scenario;
// a monitor collects transferred output beats and checks that a stalled beat
// holds still.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_comp_packer_frontend;
   localparam int DATA_W = 256;
   localparam int KEEP_W = DATA_W / 8;
   localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } beat_t;

   logic        aclk    = 1'b0;
   logic        areset  = 1'b1;
   logic        comp_en = 1'b0;
   logic        pkt_is_comp;
   logic [31:0] comp_bytes_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic rnd_ready  = 1'b0;
   logic hold_ready = 1'b1;

   beat_t rx_q[$];
   beat_t exp_q[$];

   comp_packer_frontend_if #(.DATA_W(DATA_W)) s_if ();
   comp_packer_frontend_if #(.DATA_W(DATA_W)) m_if ();

   comp_packer_frontend #(
      .DATA_W   (DATA_W),
      .LANE_W   (32),
      .HDR_BEATS(2)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .comp_en       (comp_en),
      .pkt_is_comp   (pkt_is_comp),
      .comp_bytes_out(comp_bytes_out)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Downstream ready: fixed level or random with 30% asserted.
   always @(posedge aclk) begin
      #1;
      m_if.tready = rnd_ready ? ($urandom_range(0, 99) < 30) : hold_ready;
   end

   // Output monitor, sampled on the falling edge.
   beat_t prev_beat;
   logic  prev_stall = 1'b0;
   always @(negedge aclk) begin
      if (areset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", DATA_W'(m_if.tvalid), DATA_W'(1));
            check("stall_data", m_if.tdata, prev_beat.data);
            check("stall_keep", DATA_W'(m_if.tkeep), DATA_W'(prev_beat.keep));
            check("stall_last", DATA_W'(m_if.tlast), DATA_W'(prev_beat.last));
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_beat  = beat_t'({m_if.tdata, m_if.tkeep, m_if.tlast});
         if (m_if.tvalid && m_if.tready) rx_q.push_back(prev_beat);
      end
   end

   task automatic sync();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] data,
                            input logic [KEEP_W-1:0] keep, input logic last);
      int waited = 0;
      s_if.tdata  = data;
      s_if.tkeep  = keep;
      s_if.tlast  = last;
      s_if.tvalid = 1'b1;
      forever begin
         @(negedge aclk);
         if (s_if.tready) break;
         waited++;
         if (waited > 500) begin
            check("s_accept_timeout", DATA_W'(s_if.tready), DATA_W'(1));
            break;
         end
      end
      @(posedge aclk);
      #1;
      s_if.tvalid = 1'b0;
   endtask

   task automatic push_exp(input logic [DATA_W-1:0] data,
                           input logic [KEEP_W-1:0] keep, input logic last);
      exp_q.push_back(beat_t'({data, keep, last}));
   endtask

   function automatic logic [DATA_W-1:0] hdr(input int k);
      return {8{32'hA5A5_0000 + 32'(k)}};
   endfunction

   // Both header beats of a compressed packet; comp_en is only meaningful
   // on the first one, so it is dropped right after.
   task automatic send_hdrs(input int base);
      comp_en = 1'b1;
      send_beat(hdr(base), KEEP_ALL, 1'b0);
      push_exp(hdr(base), KEEP_ALL, 1'b0);
      comp_en = 1'b0;
      send_beat(hdr(base + 1), KEEP_ALL, 1'b0);
      push_exp(hdr(base + 1), KEEP_ALL, 1'b0);
   endtask

   task automatic drain_and_compare(input string tag);
      int    n   = exp_q.size();
      int    cyc = 0;
      int    idx = 0;
      beat_t got;
      beat_t exp;
      while (rx_q.size() < n && cyc < 3000) begin
         @(negedge aclk);
         cyc++;
      end
      repeat (8) @(negedge aclk);
      check({tag, "_count"}, DATA_W'(rx_q.size()), DATA_W'(n));
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = rx_q.pop_front();
         check($sformatf("%s_b%0d_data", tag, idx), got.data, exp.data);
         check($sformatf("%s_b%0d_keep", tag, idx), DATA_W'(got.keep), DATA_W'(exp.keep));
         check($sformatf("%s_b%0d_last", tag, idx), DATA_W'(got.last), DATA_W'(exp.last));
         idx++;
      end
      exp_q.delete();
      rx_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] ones;
      logic [KEEP_W-1:0] k;
      int                exp_bytes;

      ones        = '1;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tvalid = 1'b0;

      // Reset state
      repeat (3) @(negedge aclk);
      check("rst_m_tvalid", DATA_W'(m_if.tvalid), '0);
      check("rst_m_tlast", DATA_W'(m_if.tlast), '0);
      check("rst_m_tdata", m_if.tdata, '0);
      check("rst_m_tkeep", DATA_W'(m_if.tkeep), '0);
      check("rst_s_tready", DATA_W'(s_if.tready), '0);
      check("rst_pkt_is_comp", DATA_W'(pkt_is_comp), '0);
      check("rst_comp_bytes", DATA_W'(comp_bytes_out), '0);
      sync();
      areset = 1'b0;
      repeat (3) @(negedge aclk);
      check("post_rst_no_beat", DATA_W'(m_if.tvalid), '0);

      // Bypass packet of 3 beats, last one with a partial tkeep
      sync();
      for (int i = 0; i < 3; i++) begin
         d = {8{32'h1111_0000 + 32'(i)}};
         k = (i == 2) ? 32'h0000_0FFF : KEEP_ALL;
         send_beat(d, k, i == 2);
         push_exp(d, k, i == 2);
      end
      drain_and_compare("byp");
      check("byp_pkt_is_comp", DATA_W'(pkt_is_comp), '0);
      check("byp_comp_bytes", DATA_W'(comp_bytes_out), '0);
      exp_bytes = 0;

      // Header + all-zero last payload: 16-bit zero bitmap, 2-byte tail
      sync();
      send_hdrs(0);
      send_beat('0, KEEP_ALL, 1'b1);
      push_exp('0, 32'h0000_0003, 1'b1);
      drain_and_compare("zero");
      exp_bytes += 2;
      check("zero_pkt_is_comp", DATA_W'(pkt_is_comp), DATA_W'(1));
      check("zero_comp_bytes", DATA_W'(comp_bytes_out), DATA_W'(exp_bytes));

      // Mixed lane sizes; lane3 has a disabled byte so it codes as zero
      sync();
      send_hdrs(10);
      d = {128'h0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1234, 32'h0000_0012};
      send_beat(d, 32'hFFFF_7FFF, 1'b1);
      d = {184'h0, 32'h1234_5678, 16'h1234, 8'h12, 16'h0039};
      push_exp(d, 32'h0000_01FF, 1'b1);
      drain_and_compare("mix");
      exp_bytes += 9;
      check("mix_comp_bytes", DATA_W'(comp_bytes_out), DATA_W'(exp_bytes));

      // Two all-ones payload beats: 544 bits -> 2 full beats + 4-byte tail
      sync();
      send_hdrs(20);
      send_beat(ones, KEEP_ALL, 1'b0);
      send_beat(ones, KEEP_ALL, 1'b1);
      push_exp(ones, KEEP_ALL, 1'b0);
      push_exp(ones, KEEP_ALL, 1'b0);
      push_exp({224'h0, 32'hFFFF_FFFF}, 32'h0000_000F, 1'b1);
      drain_and_compare("ones");
      exp_bytes += 68;
      check("ones_comp_bytes", DATA_W'(comp_bytes_out), DATA_W'(exp_bytes));

      // Same scenario under random backpressure
      rnd_ready = 1'b1;
      sync();
      send_hdrs(30);
      send_beat(ones, KEEP_ALL, 1'b0);
      send_beat(ones, KEEP_ALL, 1'b1);
      push_exp(ones, KEEP_ALL, 1'b0);
      push_exp(ones, KEEP_ALL, 1'b0);
      push_exp({224'h0, 32'hFFFF_FFFF}, 32'h0000_000F, 1'b1);
      drain_and_compare("rnd");
      rnd_ready = 1'b0;
      exp_bytes += 68;
      check("rnd_comp_bytes", DATA_W'(comp_bytes_out), DATA_W'(exp_bytes));

      // Reset while a full compressed beat is stuck in EMIT
      sync();
      send_hdrs(40);
      drain_and_compare("pre_rst_hdr");
      hold_ready = 1'b0;
      sync();
      send_beat(ones, KEEP_ALL, 1'b1);
      repeat (5) @(negedge aclk);
      check("stuck_valid", DATA_W'(m_if.tvalid), DATA_W'(1));
      check("stuck_last", DATA_W'(m_if.tlast), '0);
      check("stuck_data", m_if.tdata, ones);
      sync();
      areset = 1'b1;
      @(negedge aclk);
      check("mid_rst_m_tvalid", DATA_W'(m_if.tvalid), '0);
      check("mid_rst_s_tready", DATA_W'(s_if.tready), '0);
      check("mid_rst_pkt_is_comp", DATA_W'(pkt_is_comp), '0);
      check("mid_rst_comp_bytes", DATA_W'(comp_bytes_out), '0);
      hold_ready = 1'b1;
      repeat (2) @(negedge aclk);
      sync();
      areset = 1'b0;
      repeat (6) @(negedge aclk);
      check("no_stale_beat", DATA_W'(rx_q.size()), '0);
      check("no_stale_valid", DATA_W'(m_if.tvalid), '0);

      // Bypass packet after reset must come through exactly
      sync();
      for (int i = 0; i < 2; i++) begin
         d = {8{32'h7777_0000 + 32'(i)}};
         send_beat(d, KEEP_ALL, i == 1);
         push_exp(d, KEEP_ALL, i == 1);
      end
      drain_and_compare("post_rst_byp");
      check("post_rst_pkt_is_comp", DATA_W'(pkt_is_comp), '0);
      check("post_rst_comp_bytes", DATA_W'(comp_bytes_out), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
